ahb_block_ram_ctrl: RTL
=======================

# ahb_block_ram_ctrl

AHB-Lite slave front end that drives the dual-port block RAM for the Cortex-M0 SoC. It turns AHB address/data phases into the RAM's byte-enabled write port and registered read port, with zero wait states. It forwards a write that immediately precedes a read of the same word, because the RAM's registered read cannot return that write in time. It sits between the AHB decoder/mux and the RAM instance (code/data memory).

## Interface
- ADDR_WIDTH, 12, RAM word-address width (must match the RAM); memory size is 4·2^ADDR_WIDTH bytes.
- HCLK  in  1  single clock, also drives the RAM.
- HRESETn  in  1  asynchronous, active-low reset.
- HSEL  in  1  slave select from the decoder.
- HADDR  in  32  byte address; only [ADDR_WIDTH+1:0] are used.
- HTRANS  in  2  transfer type; HTRANS[1]=1 (NONSEQ/SEQ) is a valid transfer.
- HSIZE  in  3  0=byte, 1=halfword, 2=word; values >2 are treated as word.
- HWRITE  in  1  1=write.
- HWDATA  in  32  write data, valid in the data phase.
- HREADY  in  1  bus ready (address-phase qualifier).
- HREADYOUT  out  1  constant 1.
- HRESP  out  1  constant 0 (OKAY).
- HRDATA  out  32  read data.
- BRAM_WADDR  out  ADDR_WIDTH  RAM write word address.
- BRAM_WDATA  out  32  RAM write data.
- BRAM_WE  out  4  RAM byte write enables; bit i covers bits [8i+7:8i].
- BRAM_RADDR  out  ADDR_WIDTH  RAM read word address.
- BRAM_RDATA  in  32  RAM registered read data, valid one cycle after BRAM_RADDR.

## Operation
- A transfer is accepted when HSEL & HREADY & HTRANS[1] are all 1 at a rising edge.
- Word index = HADDR[ADDR_WIDTH+1:2]. Higher bits are ignored, so addresses alias modulo the memory size.
- Byte-lane decode, registered at acceptance:
  - word: 4'b1111.
  - halfword: 4'b0011 if HADDR[1]=0, else 4'b1100.
  - byte: 1 << HADDR[1:0].
  - Misaligned addresses are not detected.
- Read:
  - BRAM_RADDR = HADDR[ADDR_WIDTH+1:2] combinationally, at all times.
  - On acceptance, set rd_pend and latch rd_addr.
  - In the data phase, HRDATA = merged data; otherwise HRDATA = 0.
- Write:
  - On acceptance, set wr_pend and latch wr_addr and wr_strb.
  - In the data phase: BRAM_WADDR = wr_addr, BRAM_WDATA = HWDATA, BRAM_WE = wr_strb.
  - Outside a write data phase, BRAM_WE = 0. BRAM_WADDR and BRAM_WDATA hold the last value.
- Forwarding register, updated every cycle:
  - fwd_valid <= wr_pend.
  - When wr_pend=1, also capture fwd_addr <= wr_addr, fwd_strb <= wr_strb, fwd_data <= HWDATA.
- Merge rule: for each lane i, if fwd_valid & (fwd_addr==rd_addr) & fwd_strb[i], use fwd_data lane i; otherwise use BRAM_RDATA lane i.
- rd_pend and wr_pend clear after one data-phase cycle unless a new transfer is accepted. They are mutually exclusive.
- IDLE/BUSY transfers, HSEL=0, or HREADY=0 start no transfer.

## Timing
- Reset (async, HRESETn=0): rd_pend, wr_pend, fwd_valid, wr_strb, BRAM_WE, HRDATA, BRAM_WADDR, BRAM_WDATA = 0. HREADYOUT=1, HRESP=0.
- Read:
  - Address phase in cycle N.
  - The RAM samples BRAM_RADDR at the end of N.
  - HRDATA is valid throughout N+1. Zero wait states.
- Write:
  - Address phase in cycle N, data phase in N+1.
  - BRAM_WE is asserted during N+1 only, and memory updates at the end of N+1.
- Write in N, read of the same word in N+1:
  - The RAM read at the end of N+1 returns stale data.
  - Forwarding supplies the written lanes in N+2.
  - Unwritten lanes come from the RAM.
- Only the immediately preceding write can be stale; older writes are already in the RAM.
- Back-to-back transfers sustain one per cycle: W,W,R,R,W with no gaps.
- Reset mid-transfer: pending phases are dropped immediately. A write whose data phase is cut by reset is not performed. HRDATA goes to 0.

## Test plan
- Reset: hold HRESETn=0 with random inputs -> BRAM_WE=0, HRDATA=0, HREADYOUT=1, HRESP=0. Release; IDLE bus -> BRAM_WE stays 0.
- Word write then read: write 0xDEADBEEF to 0x0000_0010, one idle cycle, read 0x10 -> write data phase shows BRAM_WE=4'hF, BRAM_WADDR=4. HRDATA=0xDEADBEEF in the read data phase; HREADYOUT=1 in every cycle.
- Sub-word writes: word 0x20 = 0x11223344; byte write 0xAA000000 to 0x23 (BRAM_WE=4'b1000); halfword write 0x0000BBCC to 0x20 (BRAM_WE=4'b0011) -> read 0x20 returns 0xAA22BBCC.
- Forwarding: word 0x40 = 0x0; byte write 0x0000_5500 to 0x41 immediately followed by a read of 0x40 -> HRDATA=0x0000_5500 with no wait state. Repeat with a read of 0x44 -> RAM data, no forwarding.
- Non-transfers: HTRANS=IDLE, HSEL=0, or HREADY=0 with HWRITE=1 -> BRAM_WE never asserted; memory unchanged on readback.
- Aliasing and reset: with ADDR_WIDTH=12, write 0x12345678 to 0x0000_4000 -> word 0 updated. Assert HRESETn low during a write data phase -> that write is absent on readback.

Source files
------------

// File: rtl/ahb_block_ram_ctrl.sv
// AHB-Lite zero-wait-state front end for a dual-port block RAM with a registered read port.
// Forwards the immediately preceding write into a same-word read, because the RAM still returns the old data.

module ahb_bram_lane #(
  parameter int LANE_W = 8
) (
  input  logic              hit,
  input  logic [LANE_W-1:0] fwd_byte,
  input  logic [LANE_W-1:0] ram_byte,
  output logic [LANE_W-1:0] out_byte
);
  assign out_byte = hit ? fwd_byte : ram_byte;
endmodule

module ahb_block_ram_ctrl #(
  parameter int ADDR_WIDTH = 12
) (
  input  logic                  HCLK,
  input  logic                  HRESETn,
  input  logic                  HSEL,
  input  logic [31:0]           HADDR,
  input  logic [1:0]            HTRANS,
  input  logic [2:0]            HSIZE,
  input  logic                  HWRITE,
  input  logic [31:0]           HWDATA,
  input  logic                  HREADY,
  output logic                  HREADYOUT,
  output logic                  HRESP,
  output logic [31:0]           HRDATA,
  output logic [ADDR_WIDTH-1:0] BRAM_WADDR,
  output logic [31:0]           BRAM_WDATA,
  output logic [3:0]            BRAM_WE,
  output logic [ADDR_WIDTH-1:0] BRAM_RADDR,
  input  logic [31:0]           BRAM_RDATA
);
  localparam int NUM_LANES = 4;
  localparam int LANE_W    = 8;

  typedef struct packed {
    logic                  valid;
    logic [ADDR_WIDTH-1:0] addr;
    logic [NUM_LANES-1:0]  strb;
    logic [31:0]           data;
  } fwd_t;

  logic                  accept;
  logic [ADDR_WIDTH-1:0] word_idx;
  logic [NUM_LANES-1:0]  strb_dec;
  logic                  rd_pend;
  logic                  wr_pend;
  logic [ADDR_WIDTH-1:0] rd_addr;
  logic [ADDR_WIDTH-1:0] wr_addr;
  logic [NUM_LANES-1:0]  wr_strb;
  fwd_t                  fwd;
  logic                  fwd_match;
  logic [NUM_LANES-1:0][LANE_W-1:0] merged;
  logic                  unused;

  assign accept   = HSEL & HREADY & HTRANS[1];
  assign word_idx = HADDR[ADDR_WIDTH+1:2];
  assign unused   = ^{HADDR[31:ADDR_WIDTH+2], HTRANS[0]};

  always_comb begin
    strb_dec = '1;
    case (HSIZE)
      3'd0:    strb_dec = 4'b0001 << HADDR[1:0];
      3'd1:    strb_dec = HADDR[1] ? 4'b1100 : 4'b0011;
      default: strb_dec = '1;
    endcase
  end

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      rd_pend <= 1'b0;
      wr_pend <= 1'b0;
      rd_addr <= '0;
      wr_addr <= '0;
      wr_strb <= '0;
    end else begin
      rd_pend <= accept & ~HWRITE;
      wr_pend <= accept & HWRITE;
      if (accept & ~HWRITE) rd_addr <= word_idx;
      if (accept & HWRITE) begin
        wr_addr <= word_idx;
        wr_strb <= strb_dec;
      end
    end
  end

  // fwd.data doubles as the hold register for BRAM_WDATA between write data phases.
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      fwd <= '0;
    end else begin
      fwd.valid <= wr_pend;
      if (wr_pend) begin
        fwd.addr <= wr_addr;
        fwd.strb <= wr_strb;
        fwd.data <= HWDATA;
      end
    end
  end

  assign fwd_match = fwd.valid & (fwd.addr == rd_addr);

  for (genvar i = 0; i < NUM_LANES; i++) begin : g_lane
    ahb_bram_lane #(.LANE_W(LANE_W)) u_lane (
      .hit      (fwd_match & fwd.strb[i]),
      .fwd_byte (fwd.data[i*LANE_W +: LANE_W]),
      .ram_byte (BRAM_RDATA[i*LANE_W +: LANE_W]),
      .out_byte (merged[i])
    );
  end

  assign HRDATA     = rd_pend ? merged : '0;
  assign BRAM_RADDR = word_idx;
  assign BRAM_WADDR = wr_addr;
  assign BRAM_WDATA = wr_pend ? HWDATA : fwd.data;
  assign BRAM_WE    = wr_pend ? wr_strb : '0;
  assign HREADYOUT  = 1'b1;
  assign HRESP      = 1'b0;
endmodule
